// File: rtl/pe_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : pe_mem_responder
// Purpose  : Word-addressed local store that answers processing-element read
//            requests with a fixed number of wait states, a one-cycle
//            acknowledge and an out-of-range error flag. A separate preload
//            write port fills the store in any state.
// Revision : 1.0  initial release
// ============================================================================
module pe_mem_responder #(
   parameter int DEPTH       = 64,  // 32-bit words of storage, power of two
   parameter int WAIT_CYCLES = 2    // wait states between capture and ack
) (
   input  logic        clk,
   input  logic        reset,        // asynchronous, active low
   input  logic        mem_read,
   input  logic [31:0] mem_address,
   output logic        mem_ack,
   output logic [31:0] mem_Message,
   output logic        mem_err,
   output logic        busy,
   input  logic        wr_en,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data
);

   // Index width; addresses are byte addresses so the index starts at bit 2.
   localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Address decode for the request and preload ports
   // ------------------------------------------------------------------------
   logic [AW-1:0] rd_idx;
   logic          rd_in_range;
   logic [AW-1:0] wr_idx;
   logic          wr_in_range;
   logic          unused_addr_lsbs;

   assign rd_idx      = mem_address[AW+1:2];
   assign rd_in_range = (mem_address[31:AW+2] == '0);
   assign wr_idx      = wr_addr[AW+1:2];
   assign wr_in_range = (wr_addr[31:AW+2] == '0);

   // Byte-lane bits carry no meaning for word accesses.
   assign unused_addr_lsbs = ^{mem_address[1:0], wr_addr[1:0]};

   // ------------------------------------------------------------------------
   // Storage (never reset; contents undefined until preloaded)
   // ------------------------------------------------------------------------
   logic [31:0] mem [DEPTH];

   // Preload writes land on any edge; out-of-range addresses are dropped.
   always_ff @(posedge clk) begin
      if (wr_en && wr_in_range) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // ------------------------------------------------------------------------
   // Request FSM
   // ------------------------------------------------------------------------
   state_t        state_q, state_d;
   logic [3:0]    cnt_q,   cnt_d;
   logic [AW-1:0] idx_q,   idx_d;
   logic          oor_q,   oor_d;
   logic          ack_q,   ack_d;
   logic [31:0]   msg_q,   msg_d;
   logic          err_q,   err_d;

   // Next-state and registered-output logic. The storage read happens on the
   // WAIT->ACK edge, so a preload write on that same edge is not seen.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      oor_d   = oor_q;
      ack_d   = 1'b0;
      msg_d   = '0;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (mem_read) begin
               state_d = ST_WAIT;
               cnt_d   = WAIT_INIT;
               idx_d   = rd_idx;
               oor_d   = !rd_in_range;
            end
         end
         ST_WAIT: begin
            // A dropped mem_read does not abort: the request was captured.
            if (cnt_q == 4'd0) begin
               state_d = ST_ACK;
               ack_d   = 1'b1;
               if (oor_q) begin
                  err_d = 1'b1;
               end else begin
                  msg_d = mem[idx_q];
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_ACK: begin
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            // Wait for the requester to release so a held request is served once.
            if (!mem_read) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         oor_q   <= 1'b0;
         ack_q   <= 1'b0;
         msg_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         oor_q   <= oor_d;
         ack_q   <= ack_d;
         msg_q   <= msg_d;
         err_q   <= err_d;
      end
   end

   assign mem_ack     = ack_q;
   assign mem_Message = msg_q;
   assign mem_err     = err_q;
   assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pe_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_mem_responder
// Purpose  : Directed self-checking bench for pe_mem_responder. One instance
//            uses WAIT_CYCLES=2, a second uses WAIT_CYCLES=0 for the
//            back-to-back rate case. Inputs change and outputs are sampled on
//            the falling clock edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_pe_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   logic        mem_read;
   logic [31:0] mem_address;
   logic        mem_ack;
   logic [31:0] mem_Message;
   logic        mem_err;
   logic        busy;

   logic        read0;
   logic [31:0] addr0;
   logic        ack0;
   logic [31:0] msg0;
   logic        err0;
   logic        busy0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pe_mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .mem_read    (mem_read),
      .mem_address (mem_address),
      .mem_ack     (mem_ack),
      .mem_Message (mem_Message),
      .mem_err     (mem_err),
      .busy        (busy),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data)
   );

   pe_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
      .clk         (clk),
      .reset       (reset),
      .mem_read    (read0),
      .mem_address (addr0),
      .mem_ack     (ack0),
      .mem_Message (msg0),
      .mem_err     (err0),
      .busy        (busy0),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic write_word(input logic [31:0] a, input logic [31:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   // One WAIT_CYCLES=2 transaction: ack expected on the 4th edge. mem_read is
   // held through HOLD, then released. The address is scrambled after capture.
   // wr_edge (1..6, 0 = none) places a write to the same address on that edge.
   task automatic read2(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e,
                        input int wr_edge, input logic [31:0] wd, input string tag);
      mem_read    = 1'b1;
      mem_address = a;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) mem_address = 32'hFFFF_FFFC;
         chk({tag, "_ack"}, {31'd0, mem_ack}, (k == 4) ? 32'd1 : 32'd0);
         chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
         if (k == 4) begin
            chk({tag, "_data"}, mem_Message, exp_d);
            chk({tag, "_err"}, {31'd0, mem_err}, {31'd0, exp_e});
         end
         if (k == 5) begin
            chk({tag, "_data_clr"}, mem_Message, 32'd0);
            chk({tag, "_err_clr"}, {31'd0, mem_err}, 32'd0);
         end
         if (k + 1 == wr_edge) begin
            wr_en   = 1'b1;
            wr_addr = a;
            wr_data = wd;
         end else begin
            wr_en = 1'b0;
         end
      end
      wr_en    = 1'b0;
      mem_read = 1'b0;
      @(negedge clk);
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   logic [31:0] a038 [3];
   logic [31:0] d038 [3];

   // Directed sequence.
   initial begin
      a038 = '{32'h20, 32'h24, 32'h28};
      d038 = '{32'hA000_0008, 32'hA000_0009, 32'hA000_000A};
      reset = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      mem_read = 1'b0; mem_address = '0;
      read0 = 1'b0; addr0 = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ack",  {31'd0, mem_ack}, 32'd0);
      chk("rst_msg",  mem_Message, 32'd0);
      chk("rst_err",  {31'd0, mem_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_busy0", {31'd0, busy0}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_ack",  {31'd0, mem_ack}, 32'd0);

      // Preload; the write to 0x114 is out of range and must not alias word 5.
      write_word(32'h14, 32'hDEAD_BEEF);
      write_word(32'h114, 32'hBADB_AD00);
      write_word(32'h0C, 32'h11);
      write_word(32'h10, 32'h33);
      for (int i = 0; i < 3; i++) write_word(a038[i], d038[i]);

      // Basic held read, single ack
      read2(32'h14, 32'hDEAD_BEEF, 1'b0, 0, 32'd0, "r034");
      // Out of range
      read2(32'h100, 32'd0, 1'b1, 0, 32'd0, "r035");
      // Write on the WAIT->ACK edge is not seen; next read sees it
      read2(32'h0C, 32'h11, 1'b0, 4, 32'h22, "r036a");
      read2(32'h0C, 32'h22, 1'b0, 0, 32'd0, "r036b");
      // Write one edge earlier is seen
      read2(32'h10, 32'h44, 1'b0, 3, 32'h44, "r028");

      // mem_read dropped in the first WAIT cycle
      mem_read = 1'b1; mem_address = 32'h14;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) mem_read = 1'b0;
         chk("r039_ack", {31'd0, mem_ack}, (k == 4) ? 32'd1 : 32'd0);
         chk("r039_busy", {31'd0, busy}, (k <= 5) ? 32'd1 : 32'd0);
         if (k == 4) chk("r039_data", mem_Message, 32'hDEAD_BEEF);
      end

      // Reset during WAIT
      mem_read = 1'b1; mem_address = 32'h14;
      @(negedge clk);
      chk("r037_busy_wait", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      chk("r037_busy_async", {31'd0, busy}, 32'd0);
      chk("r037_ack_async",  {31'd0, mem_ack}, 32'd0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("r037_ack_in_rst", {31'd0, mem_ack}, 32'd0);
         chk("r037_busy_in_rst", {31'd0, busy}, 32'd0);
      end
      reset = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk("r037_ack", {31'd0, mem_ack}, (k == 4) ? 32'd1 : 32'd0);
         if (k == 4) chk("r037_data", mem_Message, 32'hDEAD_BEEF);
      end
      mem_read = 1'b0;
      @(negedge clk);
      chk("r037_idle", {31'd0, busy}, 32'd0);

      // Back-to-back at full rate on the WAIT_CYCLES=0 instance
      read0 = 1'b1; addr0 = a038[0];
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         chk("r038_ack", {31'd0, ack0}, ((k % 4 == 2) && (k <= 10)) ? 32'd1 : 32'd0);
         if ((k % 4 == 2) && (k <= 10)) begin
            chk("r038_data", msg0, d038[(k - 2) / 4]);
            chk("r038_err", {31'd0, err0}, 32'd0);
         end
         if (k % 4 == 3) begin
            read0 = 1'b0;
            if ((k + 1) / 4 < 3) addr0 = a038[(k + 1) / 4];
         end else if ((k % 4 == 0) && (k / 4 < 3)) begin
            read0 = 1'b1;
         end
      end
      chk("r038_idle", {31'd0, busy0}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/pe_mem_responder.md
PE_MEM_RESPONDER -- requirements
Module: pe_mem_responder

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 64, meaning the number of 32-bit words in local storage (power of two, 2..1024).
REQ-002 The block SHALL provide parameter WAIT_CYCLES, default 2, meaning the wait states between read capture and acknowledge (0..15).
REQ-003 The block SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL provide port mem_read  input  1  read request from the processing element, held high until acknowledged.
REQ-006 The block SHALL provide port mem_address  input  32  byte address of the requested word.
REQ-007 The block SHALL provide port mem_ack  output  1  one-cycle acknowledge pulse.
REQ-008 The block SHALL provide port mem_Message  output  32  read data, valid while mem_ack is high.
REQ-009 The block SHALL provide port mem_err  output  1  out-of-range flag, valid while mem_ack is high.
REQ-010 The block SHALL provide port busy  output  1  high in every state except IDLE.
REQ-011 The block SHALL provide port wr_en  input  1  preload write strobe.
REQ-012 The block SHALL provide port wr_addr  input  32  preload byte address.
REQ-013 The block SHALL provide port wr_data  input  32  preload write data.

Function
REQ-014 Word index SHALL be address[log2(DEPTH)+1:2]; address bits [1:0] are ignored; the address is in range iff bits [31:log2(DEPTH)+2] are all zero.
REQ-015 The FSM SHALL have four states: IDLE, WAIT, ACK and HOLD.
REQ-016 In IDLE with mem_read=1, the block SHALL capture mem_address on the next edge and enter WAIT, loading the wait counter with WAIT_CYCLES.
REQ-017 In WAIT, the counter SHALL decrement once per cycle; at count 0 the next edge SHALL read storage at the captured index and enter ACK.
REQ-018 When WAIT_CYCLES=0, WAIT SHALL last exactly one cycle.
REQ-019 mem_ack SHALL be high for exactly the one cycle spent in ACK; latency from the first cycle mem_read is sampled high to mem_ack high SHALL be WAIT_CYCLES+2 cycles.
REQ-020 In ACK, mem_Message SHALL equal the stored word, or 0 with mem_err=1 when out of range.
REQ-021 mem_Message and mem_err SHALL return to 0 on the edge leaving ACK.
REQ-022 ACK SHALL always transition to HOLD.
REQ-023 HOLD SHALL remain until mem_read=0 is sampled, then return to IDLE, so a held request is never served twice.
REQ-024 mem_read dropping during WAIT SHALL NOT abort the transaction; it SHALL complete through ACK and then pass directly from HOLD to IDLE.
REQ-025 Changes on mem_address after capture SHALL be ignored until the next IDLE capture.
REQ-026 A preload write with wr_en=1 and in-range wr_addr SHALL update storage on the edge in any state; an out-of-range wr_addr SHALL be dropped silently.
REQ-027 A write to the captured index on the same edge as the WAIT->ACK read SHALL NOT be visible; the read returns the old data.
REQ-028 A write on any earlier edge SHALL be visible to the read.
REQ-029 The maximum request rate SHALL be one transaction per WAIT_CYCLES+4 cycles, including one mem_read-low cycle.

Reset
REQ-030 On reset=0, the block SHALL asynchronously enter IDLE, with mem_ack=0, mem_Message=0, mem_err=0, busy=0 and the wait counter=0.
REQ-031 A reset asserted mid-transaction SHALL discard the transaction with no acknowledge; after release, a still-high mem_read SHALL be treated as a new request.
REQ-032 Storage contents SHALL NOT be cleared by reset and are undefined until preloaded.
REQ-033 Outputs SHALL leave their reset values only on a clk edge after reset deassertion.

Verification
REQ-034 Preload word 5=0xDEADBEEF, WAIT_CYCLES=2, mem_read=1 with address 0x14 held -> mem_ack pulses once on cycle 4 with mem_Message=0xDEADBEEF and mem_err=0; no second ack while mem_read stays high.
REQ-035 With DEPTH=64, read address 0x100 -> ack with mem_Message=0 and mem_err=1.
REQ-036 Preload word 3=0x11, request 0x0C, write 0x22 to 0x0C on the WAIT->ACK edge -> returns 0x11; a following read returns 0x22.
REQ-037 Assert reset during WAIT -> mem_ack never pulses and busy=0 immediately; with mem_read still high after release, a fresh ack arrives WAIT_CYCLES+2 cycles later.
REQ-038 Run back-to-back requests with one low cycle between them under WAIT_CYCLES=0 -> acks are spaced 4 cycles apart with correct data each time.
REQ-039 Drop mem_read in the first WAIT cycle -> a single ack still occurs, then IDLE is reached one cycle after ACK.
